// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice turn controller.
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROLL   = 3'd1,
        SETTLE = 3'd2,
        SCORE  = 3'd3,
        WIN    = 3'd4
    } dice_state_e;

    localparam int DICE_MIN = 1;
    localparam int DICE_MAX = 6;
    localparam int DICE_W   = 3;

    // The roller can glitch to 0 or 7 while settling; treat those as the lowest face.
    function automatic logic [DICE_W-1:0] legal_face(input logic [DICE_W-1:0] v);
        return ((v == '0) || (v == '1)) ? DICE_W'(DICE_MIN) : v;
    endfunction

endpackage

// File: rtl/dice_game_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus rising-edge detect on the synchronized level.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn};
        end
    end

    // sync_q[1] is the first metastability-safe stage; sync_q[2] is its previous value.
    assign level = sync_q[1];
    assign press = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dice_game_ctrl.sv
// Turn controller for the shared dice roller: spins while the turn holder holds their
// button, waits a settle period after release, scores the face and detects a winner.
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int SETTLE_TICKS = 8,
    parameter int WIN_SCORE    = 20,
    parameter int SCORE_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn0,
    input  logic               btn1,
    input  logic               new_game,
    input  logic [DICE_W-1:0]  dice_val,
    output logic               roll_en,
    output logic               turn,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [DICE_W-1:0]  last_roll,
    output logic               result_valid,
    output logic               winner_valid,
    output logic               winner
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;

    dice_state_e       state;
    logic [PW-1:0]     pre_cnt;
    logic [SW-1:0]     settle_cnt;
    logic              tick;
    logic              level0, press0, level1, press1;
    logic              press_cur, held_cur;
    logic [DICE_W-1:0] face;
    logic [SCORE_W:0]  sum;
    logic [SCORE_W-1:0] new_score;

    btn_sync_edge u_sync0 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn0),
        .level (level0),
        .press (press0)
    );

    btn_sync_edge u_sync1 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn1),
        .level (level1),
        .press (press1)
    );

    // Free-running settle timebase; new_game deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    always_comb begin
        press_cur = turn ? press1 : press0;
        held_cur  = turn ? level1 : level0;
        face      = legal_face(dice_val);
        sum       = {1'b0, (turn ? score1 : score0)} + {{(SCORE_W + 1 - DICE_W){1'b0}}, face};
        new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            roll_en      <= 1'b0;
            turn         <= 1'b0;
            score0       <= '0;
            score1       <= '0;
            last_roll    <= '0;
            result_valid <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
        end else if (new_game) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            roll_en      <= 1'b0;
            turn         <= 1'b0;
            score0       <= '0;
            score1       <= '0;
            last_roll    <= '0;
            result_valid <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_cur) begin
                        state   <= ROLL;
                        roll_en <= 1'b1;
                    end
                end
                ROLL: begin
                    if (!held_cur) begin
                        state      <= SETTLE;
                        roll_en    <= 1'b0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_TICKS)) begin
                        state <= SCORE;
                    end else if (tick) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SCORE: begin
                    last_roll    <= face;
                    result_valid <= 1'b1;
                    if (turn) begin
                        score1 <= new_score;
                    end else begin
                        score0 <= new_score;
                    end
                    if (new_score >= SCORE_W'(WIN_SCORE)) begin
                        state        <= WIN;
                        winner_valid <= 1'b1;
                        winner       <= turn;
                    end else begin
                        state <= IDLE;
                        turn  <= ~turn;
                    end
                end
                WIN: begin
                    roll_en <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    roll_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: directed rolls against a score/turn model.
module tb_dice_game_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int SETTLE_TICKS = 2;
    localparam int WIN_SCORE    = 10;
    localparam int SCORE_W      = 6;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               btn0 = 1'b0;
    logic               btn1 = 1'b0;
    logic               new_game = 1'b0;
    logic [2:0]         dice_val = 3'd1;
    logic               roll_en, turn, result_valid, winner_valid, winner;
    logic [SCORE_W-1:0] score0, score1;
    logic [2:0]         last_roll;

    int total = 0;
    int bad = 0;

    // Expected visible state after each scored roll: {last_roll, score0, score1, turn, winner_valid, winner}.
    logic [17:0] exp_q[$];
    logic [17:0] committed = '0;
    int p_score[2];
    int p_turn, p_win, p_winner;

    dice_game_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .SETTLE_TICKS (SETTLE_TICKS),
        .WIN_SCORE    (WIN_SCORE),
        .SCORE_W      (SCORE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn0         (btn0),
        .btn1         (btn1),
        .new_game     (new_game),
        .dice_val     (dice_val),
        .roll_en      (roll_en),
        .turn         (turn),
        .score0       (score0),
        .score1       (score1),
        .last_roll    (last_roll),
        .result_valid (result_valid),
        .winner_valid (winner_valid),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pack(input int lr, input int s0, input int s1,
                                         input int t, input int wv, input int w);
        return {3'(lr), 6'(s0), 6'(s1), 1'(t), 1'(wv), 1'(w)};
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_clear();
        p_score[0] = 0;
        p_score[1] = 0;
        p_turn     = 0;
        p_win      = 0;
        p_winner   = 0;
        exp_q.delete();
        committed  = '0;
    endtask

    task automatic model_roll(input int face);
        int f, s;
        f = (face < 1 || face > 6) ? 1 : face;
        s = p_score[p_turn] + f;
        if (s > SCORE_MAX) s = SCORE_MAX;
        p_score[p_turn] = s;
        if (s >= WIN_SCORE) begin
            p_win    = 1;
            p_winner = p_turn;
        end else begin
            p_turn = 1 - p_turn;
        end
        exp_q.push_back(pack(f, p_score[0], p_score[1], p_turn, p_win, p_winner));
    endtask

    // Every cycle out of reset the visible state must equal the last committed model state.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (result_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        committed = exp_q.pop_front();
                    end
                end
                check("state_vec", int'({last_roll, score0, score1, turn, winner_valid, winner}),
                      int'(committed));
                if (winner_valid) check("roll_en_in_win", int'(roll_en), 0);
            end
        end
    end

    task automatic wait_roll_en(input logic lvl, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (roll_en != lvl && n < 8);
        check(name, (roll_en == lvl && n >= 3 && n <= 4) ? 1 : 0, 1);
    endtask

    task automatic roll(input logic b0, input logic b1, input int face, input int hold);
        int n;
        dice_val = 3'(face);
        model_roll(face);
        @(negedge clk);
        btn0 = b0;
        btn1 = b1;
        wait_roll_en(1'b1, "roll_en_rise_latency");
        repeat (hold) @(negedge clk);
        btn0 = 1'b0;
        btn1 = 1'b0;
        wait_roll_en(1'b0, "roll_en_fall_latency");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_valid && n < 60);
        check("result_seen", int'(result_valid), 1);
        @(negedge clk);
    endtask

    task automatic no_roll(input logic b0, input logic b1, input string name);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        btn0 = b0;
        btn1 = b1;
        repeat (8) begin
            @(negedge clk);
            seen |= roll_en;
        end
        btn0 = 1'b0;
        btn1 = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= roll_en | result_valid;
        end
        check(name, int'(seen), 0);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        model_clear();
        @(negedge clk);
        check("ng_score0", int'(score0), 0);
        check("ng_score1", int'(score1), 0);
        check("ng_turn", int'(turn), 0);
        check("ng_winner_valid", int'(winner_valid), 0);
    endtask

    initial begin
        logic seen;
        int n;
        // Test 1: reset and idle
        repeat (2) @(negedge clk);
        check("rst_outputs", int'({roll_en, turn, score0, score1, last_roll,
                                   result_valid, winner_valid, winner}), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen |= roll_en;
        end
        check("idle_roll_en", int'(seen), 0);
        check("idle_turn", int'(turn), 0);

        // Test 2: single roll for player 0
        roll(1'b1, 1'b0, 5, 20);
        check("t2_score0", int'(score0), 5);
        check("t2_last_roll", int'(last_roll), 5);
        check("t2_turn", int'(turn), 1);

        // Test 3: wrong player ignored, simultaneous press goes to turn holder
        do_new_game();
        no_roll(1'b0, 1'b1, "t3_btn1_ignored");
        roll(1'b1, 1'b1, 4, 6);
        check("t3_score0", int'(score0), 4);
        check("t3_score1", int'(score1), 0);
        check("t3_turn", int'(turn), 1);

        // Test 4: play to a win, presses ignored while won
        do_new_game();
        roll(1'b1, 1'b0, 6, 5);
        roll(1'b0, 1'b1, 3, 5);
        roll(1'b1, 1'b0, 6, 5);
        check("t4_score0", int'(score0), 12);
        check("t4_score1", int'(score1), 3);
        check("t4_winner_valid", int'(winner_valid), 1);
        check("t4_winner", int'(winner), 0);
        no_roll(1'b1, 1'b0, "t4_btn0_in_win");
        no_roll(1'b0, 1'b1, "t4_btn1_in_win");
        check("t4_score0_held", int'(score0), 12);
        do_new_game();

        // Test 5: out-of-range faces score as 1
        roll(1'b1, 1'b0, 7, 4);
        check("t5_score0", int'(score0), 1);
        roll(1'b0, 1'b1, 0, 4);
        check("t5_score1", int'(score1), 1);
        check("t5_last_roll", int'(last_roll), 1);

        // Test 6a: reset during ROLL
        do_new_game();
        dice_val = 3'd5;
        @(negedge clk);
        btn0 = 1'b1;
        wait_roll_en(1'b1, "t6_roll_en_rise");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_roll_en", int'(roll_en), 0);
        check("t6_rst_score0", int'(score0), 0);
        model_clear();
        btn0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= result_valid | roll_en;
        end
        check("t6_no_result_after_rst", int'(seen), 0);

        // Test 6b: new_game during SETTLE
        @(negedge clk);
        btn0 = 1'b1;
        wait_roll_en(1'b1, "t6b_roll_en_rise");
        repeat (3) @(negedge clk);
        btn0 = 1'b0;
        wait_roll_en(1'b0, "t6b_roll_en_fall");
        do_new_game();
        seen = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= result_valid;
            n++;
        end
        check("t6b_no_result", int'(seen), 0);
        check("t6b_score0", int'(score0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
